// File: rtl/led_pwm_bank.sv
// Bank of LED PWM channels sharing one prescaled phase counter.
// Duties are double-buffered and reach the comparators only at period wrap.
module led_pwm_bank #(
   parameter int CHANNELS   = 4,
   parameter int WIDTH      = 8,
   parameter int PRESCALE   = 100,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                we,
   input  logic [7:0]          addr,
   input  logic [WIDTH-1:0]    wdata,
   output logic [CHANNELS-1:0] led,
   output logic                period_done,
   output logic                err
);

   localparam int              PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PMAX = PW'(PRESCALE - 1);
   localparam logic [7:0]      NCH  = 8'(CHANNELS);

   logic [PW-1:0]    pcnt;
   logic [WIDTH-1:0] phase;
   logic [WIDTH-1:0] pending [CHANNELS];
   logic [WIDTH-1:0] active  [CHANNELS];

   logic tick;
   logic wrap;
   logic load;
   logic bad_wr;

   assign tick   = (pcnt == PMAX);
   assign wrap   = en & tick & (&phase);
   // While disabled the active set tracks pending continuously.
   assign load   = wrap | ~en;
   assign bad_wr = we & (addr >= NCH);

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt        <= '0;
         phase       <= '0;
         period_done <= 1'b0;
         err         <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            pending[i] <= '0;
            active[i]  <= '0;
            led[i]     <= ACTIVE_LOW;
         end
      end else begin
         period_done <= wrap;
         err         <= bad_wr;

         if (!en) begin
            pcnt  <= '0;
            phase <= '0;
         end else if (tick) begin
            pcnt  <= '0;
            phase <= phase + WIDTH'(1);
         end else begin
            pcnt  <= pcnt + PW'(1);
         end

         for (int i = 0; i < CHANNELS; i++) begin
            // A write landing on a wrap goes straight into the new period.
            if (we && addr == 8'(i)) begin
               pending[i] <= wdata;
               if (load)
                  active[i] <= wdata;
            end else if (load) begin
               active[i] <= pending[i];
            end

            if (en)
               led[i] <= (phase < active[i]) ^ ACTIVE_LOW;
            else
               led[i] <= ACTIVE_LOW;
         end
      end
   end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank: two copies (active-high and active-low)
// share stimulus; per-period high counts are checked against hand values.
module tb_led_pwm_bank;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b1;
   logic       we = 1'b0;
   logic [7:0] addr = 8'd0;
   logic [3:0] wdata = 4'd0;
   logic [3:0] led;
   logic [3:0] led_n;
   logic       period_done;
   logic       period_done_n;
   logic       err;
   logic       err_n;

   int nchk = 0;
   int nfail = 0;
   int n;

   always #5 clk = ~clk;

   led_pwm_bank #(
      .CHANNELS(4), .WIDTH(4), .PRESCALE(2), .ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .we(we),
      .addr(addr), .wdata(wdata),
      .led(led), .period_done(period_done), .err(err)
   );

   led_pwm_bank #(
      .CHANNELS(4), .WIDTH(4), .PRESCALE(2), .ACTIVE_LOW(1'b1)
   ) dut_n (
      .clk(clk), .reset(reset), .en(en), .we(we),
      .addr(addr), .wdata(wdata),
      .led(led_n), .period_done(period_done_n), .err(err_n)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_led"}, int'(led), 0);
      chk({tag, "_led_n"}, int'(led_n), 15);
      chk({tag, "_pd"}, int'(period_done), 0);
      chk({tag, "_err"}, int'(err), 0);
   endtask

   task automatic wr(input logic [7:0] a, input logic [3:0] d);
      we = 1'b1;
      addr = a;
      wdata = d;
      tick();
      we = 1'b0;
   endtask

   // Counts edges until period_done is seen; 101 means it never came.
   task automatic wait_pd(output int cnt);
      cnt = 101;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (period_done) begin
            cnt = k;
            break;
         end
      end
   endtask

   // Called right after period_done is seen: observes the 32 led samples
   // of the period just started, optionally injecting one write at sample wat.
   task automatic measure(input string tag, input int wat,
                          input logic [7:0] wa, input logic [3:0] wd,
                          input int e0, input int e1, input int e2,
                          input int e3, input int eerr);
      int c [4];
      int npd;
      int nerr;
      int nbad;
      for (int i = 0; i < 4; i++) c[i] = 0;
      npd = 0;
      nerr = 0;
      nbad = 0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         we = 1'b0;
         for (int i = 0; i < 4; i++) c[i] += led[i] ? 1 : 0;
         npd += period_done ? 1 : 0;
         nerr += err ? 1 : 0;
         if (led_n !== ~led) nbad++;
         if (k == wat) begin
            we = 1'b1;
            addr = wa;
            wdata = wd;
         end
      end
      chk({tag, "_ch0"}, c[0], e0);
      chk({tag, "_ch1"}, c[1], e1);
      chk({tag, "_ch2"}, c[2], e2);
      chk({tag, "_ch3"}, c[3], e3);
      chk({tag, "_pd_count"}, npd, 1);
      chk({tag, "_pd_end"}, int'(period_done), 1);
      chk({tag, "_err_count"}, nerr, eerr);
      chk({tag, "_led_n_inv"}, nbad, 0);
   endtask

   initial begin
      // Reset held three cycles with en asserted
      for (int r = 0; r < 3; r++) begin
         tick();
         chk_idle("reset");
      end
      reset = 1'b0;
      tick();
      chk_idle("reset_release");

      wr(8'd0, 4'd4);
      wr(8'd1, 4'd0);
      wr(8'd2, 4'd15);
      wr(8'd3, 4'd8);
      chk("pre_wrap_led", int'(led), 0);
      wait_pd(n);
      chk("first_wrap_seen", (n <= 32) ? 1 : 0, 1);

      measure("basic", 0, 8'd0, 4'd0, 8, 0, 30, 16, 0);
      measure("midwrite", 10, 8'd0, 4'd8, 8, 0, 30, 16, 0);
      measure("wrapwrite", 31, 8'd0, 4'd2, 16, 0, 30, 16, 0);
      measure("badaddr", 5, 8'd7, 4'd9, 4, 0, 30, 16, 1);
      measure("after_bad", 0, 8'd0, 4'd0, 4, 0, 30, 16, 0);

      // Disable: inactive level next cycle, no period_done
      en = 1'b0;
      tick();
      chk("dis_led", int'(led), 0);
      chk("dis_led_n", int'(led_n), 15);
      chk("dis_pd", int'(period_done), 0);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (period_done || led !== 4'h0 || led_n !== 4'hF) n++;
      end
      chk("dis_hold", n, 0);

      en = 1'b1;
      wait_pd(n);
      chk("en_restart_cycles", n, 32);
      measure("reenabled", 0, 8'd0, 4'd0, 4, 0, 30, 16, 0);

      // Reset mid-period clears counters and duties
      for (int k = 0; k < 7; k++) tick();
      reset = 1'b1;
      tick();
      chk_idle("midreset_a");
      tick();
      chk_idle("midreset_b");
      reset = 1'b0;
      wait_pd(n);
      chk("midreset_restart", n, 32);
      measure("cleared", 0, 8'd0, 4'd0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule

// File: doc/led_pwm_bank.md
LED_PWM_BANK -- requirements
Module: led_pwm_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of LED channels (1..32).
REQ-002 SHALL have parameter WIDTH, default 8: duty/phase resolution in bits (2..16).
REQ-003 SHALL have parameter PRESCALE, default 100: clk cycles per phase step (>=1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 0: 1 inverts all led outputs.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port en, input, 1: global PWM enable.
REQ-008 SHALL have port we, input, 1: duty write strobe.
REQ-009 SHALL have port addr, input, 8: channel index for a write.
REQ-010 SHALL have port wdata, input, WIDTH: duty value for a write.
REQ-011 SHALL have port led, output, CHANNELS: registered LED drive.
REQ-012 SHALL have port period_done, output, 1: one-cycle pulse at each PWM period wrap.
REQ-013 SHALL have port err, output, 1: one-cycle pulse on an invalid write.

Function
REQ-014 SHALL keep a prescaler counting 0..PRESCALE-1, with a tick in the cycle where the count equals PRESCALE-1 (tick every cycle when PRESCALE=1).
REQ-015 SHALL keep a WIDTH-bit phase counter, incremented on tick and wrapping from 2^WIDTH-1 to 0; PWM period = PRESCALE*2^WIDTH cycles.
REQ-016 SHALL define wrap as tick with phase==2^WIDTH-1 and pulse period_done for exactly that cycle (registered, visible the next cycle).
REQ-017 SHALL hold per-channel pending and active duty registers, each WIDTH bits.
REQ-018 SHALL load pending[addr] with wdata when we=1 and addr<CHANNELS.
REQ-019 SHALL ignore a write with addr>=CHANNELS, leaving all duties unchanged, and pulse err for one cycle (registered).
REQ-020 SHALL copy every pending duty into the matching active duty on wrap, so duty changes never take effect mid-period.
REQ-021 SHALL give precedence to wdata when a valid write and a wrap occur in the same cycle: both pending and active of that channel take wdata.
REQ-022 SHALL compute led[i] = (phase < active[i]) registered, one cycle after phase/active update; XOR with ACTIVE_LOW at output.
REQ-023 SHALL therefore keep duty 0 permanently inactive and give duty 2^WIDTH-1 active for all but one phase step per period.
REQ-024 SHALL, while en=0: hold prescaler and phase at 0, copy pending to active every cycle, force led to inactive level, and suppress period_done; writes and err remain functional.
REQ-025 SHALL restart from prescaler=0, phase=0 on the cycle after en rises; first period is a full period.

Reset
REQ-026 SHALL, with reset=1 at a clock edge, clear prescaler, phase, all pending and active duties, period_done and err, and drive led to the inactive level (0 if ACTIVE_LOW=0, all-ones if 1), overriding en and we.
REQ-027 SHALL apply reset mid-period identically, with no carry-over of any counter or duty state.

Verification
REQ-028 SHALL cover reset: CHANNELS=4, WIDTH=4, PRESCALE=2, en=1, reset high 3 cycles -> led=4'b0000, period_done=0, err=0 throughout and the cycle after release.
REQ-029 SHALL cover basic duty: write ch0=4, en=1 -> from the first period after wrap, led[0] high 8 of every 32 cycles; period_done pulses every 32 cycles.
REQ-030 SHALL cover extremes: ch1=0, ch2=15 -> led[1] never high; led[2] high 30 of 32 cycles.
REQ-031 SHALL cover double-buffering: ch0=4, write ch0=8 mid-period -> current period 8 high cycles, next period 16 high cycles; write coinciding with wrap -> new value used in that very period.
REQ-032 SHALL cover invalid address: write addr=7 with wdata=9 -> err high exactly one cycle, all duties and led pattern unchanged.
REQ-033 SHALL cover en toggle and ACTIVE_LOW=1: en=0 -> led=4'b1111 next cycle, no period_done; en=1 -> phase restarts at 0 and first period_done arrives after exactly 32 cycles.
